branch_predictor: RTL

//  Parametrised dynamic branch predictor (BHT + BTB) for the 5-stage core; replaces static predict-not-taken.

---
 rtl/riscv_bp_pkg.sv | 22 ++
 rtl/bp_sat_counter.sv | 37 +++
 rtl/branch_predictor.sv | 115 +++++++++++
 3 files changed

// File: rtl/riscv_bp_pkg.sv
// Shared definitions for the dynamic branch predictor.
//   MODE_STATIC / MODE_BIMODAL : prediction mode selector values
//   ctr_wnt(bits)              : weakly-not-taken value for a saturating counter
//   sat_step(ctr, up, bits)    : one saturating step up or down, no wrap
package riscv_bp_pkg;

  localparam int MODE_STATIC  = 0;
  localparam int MODE_BIMODAL = 1;

  function automatic int ctr_wnt(input int ctr_bits);
    return (1 << (ctr_bits - 1)) - 1;
  endfunction

  function automatic logic [31:0] sat_step(input logic [31:0] ctr, input logic up,
                                           input int ctr_bits);
    logic [31:0] max_v;
    max_v = (32'd1 << ctr_bits) - 32'd1;
    if (up) return (ctr >= max_v) ? max_v : ctr + 32'd1;
    else    return (ctr == 32'd0) ? 32'd0 : ctr - 32'd1;
  endfunction

endpackage

// File: rtl/bp_sat_counter.sv
// Saturating up/down counter used as one BHT entry.
//   clk, rst      : clock, synchronous active-low reset (resets to WNT)
//   load/load_val : overwrite with load_val (priority over inc/dec)
//   inc/dec       : saturating step up/down
//   ctr           : current counter value
module bp_sat_counter
  import riscv_bp_pkg::*;
#(
  parameter int CTR_BITS = 2
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                load,
  input  logic [CTR_BITS-1:0] load_val,
  input  logic                inc,
  input  logic                dec,
  output logic [CTR_BITS-1:0] ctr
);

  localparam logic [CTR_BITS-1:0] WNT = CTR_BITS'(ctr_wnt(CTR_BITS));

  logic [CTR_BITS-1:0] ctr_q, ctr_d;

  always_comb begin
    ctr_d = ctr_q;
    if (load)           ctr_d = load_val;
    else if (inc | dec) ctr_d = CTR_BITS'(sat_step(32'(ctr_q), inc, CTR_BITS));
  end

  always_ff @(posedge clk) begin
    if (!rst) ctr_q <= WNT;
    else      ctr_q <= ctr_d;
  end

  assign ctr = ctr_q;

endmodule

// File: rtl/branch_predictor.sv
// Dynamic branch predictor (BHT + BTB) for the 5-stage core.
//   if_pc -> pred_taken / pred_target       : zero-latency lookup for fetch
//   ex_*                                     : resolved branch from EX, trains tables
//   mispredict / redirect_pc                 : combinational redirect for PC select/flush
//   branch_count / mispred_count             : saturating statistics since reset
//   clk, rst                                 : clock, synchronous active-low reset
module branch_predictor
  import riscv_bp_pkg::*;
#(
  parameter int XLEN     = 32,
  parameter int ENTRIES  = 64,
  parameter int TAG_W    = 10,
  parameter int CTR_BITS = 2,
  parameter int MODE     = 1,
  parameter int STAT_W   = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [XLEN-1:0]   if_pc,
  output logic              pred_taken,
  output logic [XLEN-1:0]   pred_target,
  input  logic              ex_valid,
  input  logic              ex_is_branch,
  input  logic [XLEN-1:0]   ex_pc,
  input  logic              ex_taken,
  input  logic [XLEN-1:0]   ex_target,
  input  logic              ex_pred_taken,
  input  logic [XLEN-1:0]   ex_pred_target,
  output logic              mispredict,
  output logic [XLEN-1:0]   redirect_pc,
  output logic [STAT_W-1:0] branch_count,
  output logic [STAT_W-1:0] mispred_count
);

  localparam int IDX_W = $clog2(ENTRIES);
  localparam logic [CTR_BITS-1:0] WNT    = CTR_BITS'(ctr_wnt(CTR_BITS));
  localparam logic [CTR_BITS-1:0] WNT_P1 = WNT + CTR_BITS'(1);

  logic [ENTRIES-1:0] valid_q;
  logic [TAG_W-1:0]   tag_q [ENTRIES];
  logic [XLEN-1:0]    btb_q [ENTRIES];
  logic [CTR_BITS-1:0] ctr_w [ENTRIES];
  logic [STAT_W-1:0]  bcnt_q, bcnt_d, mcnt_q, mcnt_d;

  logic [IDX_W-1:0] lk_idx, ex_idx;
  logic [TAG_W-1:0] lk_tag, ex_tag;
  logic             lk_hit, ex_hit, upd;

  assign lk_idx = if_pc[IDX_W+1:2];
  assign lk_tag = if_pc[IDX_W+TAG_W+1:IDX_W+2];
  assign ex_idx = ex_pc[IDX_W+1:2];
  assign ex_tag = ex_pc[IDX_W+TAG_W+1:IDX_W+2];

  assign lk_hit = valid_q[lk_idx] && (tag_q[lk_idx] == lk_tag);
  assign ex_hit = valid_q[ex_idx] && (tag_q[ex_idx] == ex_tag);
  assign upd    = ex_valid & ex_is_branch;

  // Lookup sees only registered state, so a same-cycle update to the same
  // entry is not visible until the following cycle.
  assign pred_taken  = (MODE == MODE_BIMODAL) && lk_hit && ctr_w[lk_idx][CTR_BITS-1];
  assign pred_target = pred_taken ? btb_q[lk_idx] : if_pc + XLEN'(4);

  // Last term catches a BTB alias that predicted taken on a non-branch.
  assign mispredict = (upd && (ex_taken != ex_pred_taken))
                   || (upd && ex_taken && ex_pred_taken && (ex_target != ex_pred_target))
                   || (ex_valid && !ex_is_branch && ex_pred_taken);
  assign redirect_pc = (upd && ex_taken) ? ex_target : ex_pc + XLEN'(4);

  for (genvar g = 0; g < ENTRIES; g++) begin : g_bht
    logic sel;
    assign sel = upd && (ex_idx == IDX_W'(g));
    bp_sat_counter #(.CTR_BITS(CTR_BITS)) u_ctr (
      .clk      (clk),
      .rst      (rst),
      .load     (sel && !ex_hit),
      .load_val (ex_taken ? WNT_P1 : WNT),
      .inc      (sel && ex_hit && ex_taken),
      .dec      (sel && ex_hit && !ex_taken),
      .ctr      (ctr_w[g])
    );
  end

  always_comb begin
    bcnt_d = bcnt_q;
    mcnt_d = mcnt_q;
    if (upd && (bcnt_q != '1))        bcnt_d = bcnt_q + STAT_W'(1);
    if (mispredict && (mcnt_q != '1)) mcnt_d = mcnt_q + STAT_W'(1);
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      valid_q <= '0;
      for (int i = 0; i < ENTRIES; i++) begin
        tag_q[i] <= '0;
        btb_q[i] <= '0;
      end
      bcnt_q <= '0;
      mcnt_q <= '0;
    end else begin
      if (upd) begin
        if (!ex_hit) begin
          valid_q[ex_idx] <= 1'b1;
          tag_q[ex_idx]   <= ex_tag;
        end
        if (ex_taken) btb_q[ex_idx] <= ex_target;
      end
      bcnt_q <= bcnt_d;
      mcnt_q <= mcnt_d;
    end
  end

  assign branch_count  = bcnt_q;
  assign mispred_count = mcnt_q;

endmodule
